// File: rtl/fb_rect_fill_writer_if.sv
// Command and framebuffer-write bundle for the rectangle fill engine.
// The master side is the engine; the slave side is the command source and the write port.
interface fb_rect_fill_writer_if #(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 9,
  parameter int unsigned CW = 8,
  parameter int unsigned PW = 17
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [XW-1:0] cmd_x0;
  logic [YW-1:0] cmd_y0;
  logic [XW-1:0] cmd_x1;
  logic [YW-1:0] cmd_y1;
  logic [CW-1:0] cmd_color;
  logic          stall;
  logic          we;
  logic [XW-1:0] wr_pxl_x;
  logic [YW-1:0] wr_pxl_y;
  logic [CW-1:0] wr_palette_index;
  logic          busy;
  logic          done;
  logic [PW-1:0] pixel_count;

  modport master (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, stall,
    output cmd_ready, we, wr_pxl_x, wr_pxl_y, wr_palette_index, busy, done, pixel_count
  );

  modport slave (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, stall,
    input  cmd_ready, we, wr_pxl_x, wr_pxl_y, wr_palette_index, busy, done, pixel_count
  );
endinterface

// File: rtl/fb_rect_fill_writer.sv
// Rectangle fill engine: clips one command to the screen and writes one pixel per cycle
// in raster order to the framebuffer write port.
module fb_rect_fill_writer #(
  parameter int unsigned RESOLUTION_X   = 400,
  parameter int unsigned RESOLUTION_Y   = 300,
  parameter int unsigned PALETTE_LENGTH = 256
) (
  input logic                   wr_clk,
  input logic                   reset,
  fb_rect_fill_writer_if.master bus
);
  localparam int unsigned XW = $clog2(RESOLUTION_X);
  localparam int unsigned YW = $clog2(RESOLUTION_Y);
  localparam int unsigned CW = $clog2(PALETTE_LENGTH);
  localparam int unsigned PW = $clog2(RESOLUTION_X * RESOLUTION_Y + 1);
  localparam logic [XW-1:0] XMax = XW'(RESOLUTION_X - 1);
  localparam logic [YW-1:0] YMax = YW'(RESOLUTION_Y - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e        state_q;
  logic [XW-1:0] x0_q, x1c_q, x_q;
  logic [YW-1:0] y1c_q, y_q;
  logic [CW-1:0] color_q;
  logic [PW-1:0] count_q, pixel_count_q;

  logic [XW-1:0] x1c;
  logic [YW-1:0] y1c;
  logic          empty;
  logic          accept;

  // Clamp the far corner; an out-of-screen near corner then shows up as an empty range.
  always_comb begin
    x1c   = (bus.cmd_x1 > XMax) ? XMax : bus.cmd_x1;
    y1c   = (bus.cmd_y1 > YMax) ? YMax : bus.cmd_y1;
    empty = (bus.cmd_x0 > x1c) || (bus.cmd_y0 > y1c);
  end

  assign bus.cmd_ready        = (state_q == StIdle) && !reset;
  assign accept               = bus.cmd_valid && bus.cmd_ready;
  assign bus.we               = (state_q == StFill) && !bus.stall;
  assign bus.busy             = (state_q != StIdle);
  assign bus.done             = (state_q == StDone);
  assign bus.wr_pxl_x         = x_q;
  assign bus.wr_pxl_y         = y_q;
  assign bus.wr_palette_index = color_q;
  assign bus.pixel_count      = pixel_count_q;

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q       <= StIdle;
      x0_q          <= '0;
      x1c_q         <= '0;
      y1c_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      count_q       <= '0;
      pixel_count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (empty) begin
              state_q       <= StDone;
              pixel_count_q <= '0;
            end else begin
              state_q <= StFill;
              x0_q    <= bus.cmd_x0;
              x1c_q   <= x1c;
              y1c_q   <= y1c;
              x_q     <= bus.cmd_x0;
              y_q     <= bus.cmd_y0;
              color_q <= bus.cmd_color;
              count_q <= '0;
            end
          end
        end
        StFill: begin
          if (!bus.stall) begin
            count_q <= count_q + PW'(1);
            if (x_q == x1c_q) begin
              if (y_q == y1c_q) begin
                state_q       <= StDone;
                pixel_count_q <= count_q + PW'(1);
              end else begin
                x_q <= x0_q;
                y_q <= y_q + YW'(1);
              end
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_rect_fill_writer.sv
// Bench for fb_rect_fill_writer: directed and randomized fills checked against a
// list of expected pixels built from the clipping rules.
module tb_fb_rect_fill_writer;
  localparam int RX = 400;
  localparam int RY = 300;
  localparam int PL = 256;
  localparam int XW = $clog2(RX);
  localparam int YW = $clog2(RY);
  localparam int CW = $clog2(PL);
  localparam int PW = $clog2(RX * RY + 1);

  typedef struct {
    int x;
    int y;
  } pix_t;

  logic wr_clk = 1'b0;
  logic reset  = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  fb_rect_fill_writer_if #(.XW(XW), .YW(YW), .CW(CW), .PW(PW)) bus ();

  fb_rect_fill_writer #(
    .RESOLUTION_X  (RX),
    .RESOLUTION_Y  (RY),
    .PALETTE_LENGTH(PL)
  ) dut (
    .wr_clk(wr_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive a command at a falling edge; returns at the falling edge after the accept edge.
  task automatic present(input int x0, input int y0, input int x1, input int y1, input int c);
    @(negedge wr_clk);
    bus.cmd_x0    = XW'(x0);
    bus.cmd_y0    = YW'(y0);
    bus.cmd_x1    = XW'(x1);
    bus.cmd_y1    = YW'(y1);
    bus.cmd_color = CW'(c);
    bus.cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge wr_clk);
  endtask

  // smode: 0 no stall, 1 random stall, 2 stall in cycles 2..4 after accept.
  task automatic track(input int x0, input int y0, input int x1, input int y1, input int c,
                       input int smode);
    pix_t q[$];
    pix_t p;
    int   x1c, y1c, npix, nstall, k, budget;
    bit   s;
    x1c = (x1 > RX - 1) ? RX - 1 : x1;
    y1c = (y1 > RY - 1) ? RY - 1 : y1;
    for (int yy = y0; yy <= y1c; yy++) begin
      for (int xx = x0; xx <= x1c; xx++) begin
        p.x = xx;
        p.y = yy;
        q.push_back(p);
      end
    end
    npix   = q.size();
    nstall = 0;
    budget = 4 * npix + 20;
    k      = 1;
    while (k <= budget) begin
      case (smode)
        1:       s = ($urandom_range(0, 3) == 0);
        2:       s = (k >= 2 && k <= 4);
        default: s = 1'b0;
      endcase
      bus.stall = s;
      #1;
      chk("busy", bus.busy, 1);
      chk("cmd_ready_busy", bus.cmd_ready, 0);
      if (bus.done === 1'b1) break;
      if (s) begin
        nstall++;
        chk("we_stalled", bus.we, 0);
        if (q.size() > 0) begin
          chk("x_frozen", bus.wr_pxl_x, q[0].x);
          chk("y_frozen", bus.wr_pxl_y, q[0].y);
        end
      end else begin
        chk("we", bus.we, 1);
        if (q.size() == 0) begin
          chk("extra_write_we", bus.we, 0);
        end else begin
          p = q.pop_front();
          chk("wr_pxl_x", bus.wr_pxl_x, p.x);
          chk("wr_pxl_y", bus.wr_pxl_y, p.y);
          chk("wr_palette_index", bus.wr_palette_index, c);
        end
      end
      @(negedge wr_clk);
      k++;
    end
    bus.stall = 1'b0;
    if (k > budget) begin
      #1;
      chk("done_timeout", bus.done, 1);
    end else begin
      chk("done_cycle", k, npix + nstall + 1);
      chk("we_in_done", bus.we, 0);
      chk("pixel_count", bus.pixel_count, npix);
      chk("pixels_missing", q.size(), 0);
    end
  endtask

  task automatic finish_cmd();
    @(negedge wr_clk);
    #1;
    chk("cmd_ready_after", bus.cmd_ready, 1);
    chk("busy_after", bus.busy, 0);
    chk("done_after", bus.done, 0);
  endtask

  initial begin
    int x0, y0, x1, y1, c;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;
    bus.stall     = 1'b0;

    // Reset state, with a command presented to show it is not taken.
    repeat (2) @(negedge wr_clk);
    bus.cmd_valid = 1'b1;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_x", bus.wr_pxl_x, 0);
    chk("rst_y", bus.wr_pxl_y, 0);
    chk("rst_idx", bus.wr_palette_index, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pixel_count", bus.pixel_count, 0);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge wr_clk);
    bus.stall = 1'b1;
    #1;
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_we_stall", bus.we, 0);
    bus.stall = 1'b0;

    // Basic 3x2 fill.
    present(2, 3, 4, 4, 8'h5A);
    bus.cmd_valid = 1'b0;
    track(2, 3, 4, 4, 8'h5A, 0);
    finish_cmd();

    // Clipped at the bottom-right corner.
    c = $urandom_range(0, 255);
    present(398, 298, 511, 511, c);
    bus.cmd_valid = 1'b0;
    track(398, 298, 511, 511, c, 0);
    finish_cmd();

    // Empty commands.
    present(10, 0, 5, 0, 1);
    bus.cmd_valid = 1'b0;
    track(10, 0, 5, 0, 1, 0);
    finish_cmd();
    present(450, 0, 460, 0, 2);
    bus.cmd_valid = 1'b0;
    track(450, 0, 460, 0, 2, 0);
    finish_cmd();

    // Randomized commands with random stalls, including edge-clipped and empty ones.
    for (int i = 0; i < 10; i++) begin
      x0 = (i % 3 == 0) ? $urandom_range(385, 420) : $urandom_range(0, 399);
      y0 = (i % 4 == 0) ? $urandom_range(285, 310) : $urandom_range(0, 299);
      x1 = x0 + $urandom_range(0, 12) - ((i % 5 == 4) ? 14 : 0);
      y1 = y0 + $urandom_range(0, 10);
      if (x1 < 0) x1 = 0;
      if (x1 > 511) x1 = 511;
      if (y1 > 511) y1 = 511;
      c = $urandom_range(0, 255);
      present(x0, y0, x1, y1, c);
      bus.cmd_valid = 1'b0;
      track(x0, y0, x1, y1, c, 1);
      finish_cmd();
    end

    // Back-to-back: second command held valid during the first fill.
    present(5, 5, 7, 6, 8'h11);
    bus.cmd_x0    = XW'(100);
    bus.cmd_y0    = YW'(200);
    bus.cmd_x1    = XW'(101);
    bus.cmd_y1    = YW'(202);
    bus.cmd_color = CW'(8'hC3);
    track(5, 5, 7, 6, 8'h11, 1);
    @(negedge wr_clk);
    #1;
    chk("b2b_cmd_ready", bus.cmd_ready, 1);
    @(negedge wr_clk);
    bus.cmd_valid = 1'b0;
    track(100, 200, 101, 202, 8'hC3, 0);
    finish_cmd();

    // Width-1 column with stall over cycles 2..4.
    present(7, 10, 7, 12, 8'h33);
    bus.cmd_valid = 1'b0;
    track(7, 10, 7, 12, 8'h33, 2);
    finish_cmd();

    // Reset in the middle of a 10x10 fill.
    present(20, 20, 29, 29, 8'h77);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("pre_reset_we", bus.we, 1);
      @(negedge wr_clk);
    end
    reset = 1'b1;
    @(negedge wr_clk);
    #1;
    chk("mid_rst_we", bus.we, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_x", bus.wr_pxl_x, 0);
    chk("mid_rst_y", bus.wr_pxl_y, 0);
    chk("mid_rst_idx", bus.wr_palette_index, 0);
    chk("mid_rst_pixel_count", bus.pixel_count, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    reset = 1'b0;
    @(negedge wr_clk);
    #1;
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    chk("post_rst_we", bus.we, 0);
    chk("post_rst_done", bus.done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
